logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit. Generalises the fixed 8-bit XNOR
//  unit to WIDTH bits and 8 selectable ops, and adds result flags.
//  Sits in each core's execute stage of the multiprocessor datapath. A TAG
//  travels with each op so results can be routed back to the issuing core/register.
//  Two-stage pipeline with valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=2)
//  TAG_W   4  width of the pass-through tag (>=1)
// PORTS
//  clk        in   1               rising-edge clock
//  rst_n      in   1               asynchronous reset, active-low
//  in_valid   in   1               operands/op/tag valid this cycle
//  in_ready   out  1               unit can accept this cycle
//  in_op      in   3               operation select (see BEHAVIOUR)
//  in_a       in   WIDTH           operand A
//  in_b       in   WIDTH           operand B
//  in_tag     in   TAG_W           opaque tag, returned unchanged
//  out_valid  out  1               result valid
//  out_ready  in   1               consumer accepts result
//  out_result out  WIDTH           bitwise result
//  out_tag    out  TAG_W           tag of this result
//  out_zero   out  1               result == 0
//  out_ones   out  1               result == all ones
//  out_parity out  1               XOR-reduction of result (1 = odd count)
//  out_pop    out  $clog2(WIDTH+1) number of 1 bits in result
// BEHAVIOUR
//  - Ops: 000 AND, 001 OR, 010 XOR, 011 XNOR, 100 NAND, 101 NOR, 110 NOT A,
//    111 PASS A. in_b is ignored for 110/111.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//  - Global advance enable: adv = ~out_valid | out_ready; in_ready = adv
//    (combinational from out_ready/out_valid only; never depends on in_valid).
//  - Stage 1 (S1), on adv:
//    - S1 captures {valid = in_valid & adv, op result, tag}.
//    - The result is computed combinationally from in_* before the S1 register.
//    - An invalid input loads a bubble (S1 valid = 0); data contents are don't-care.
//  - Stage 2 (S2), on adv:
//    - S2 captures S1 valid/result/tag.
//    - S2 also registers zero/ones/parity/popcount, computed from the S1 result.
//  - All out_* ports are driven directly from S2 registers.
//  - Latency: exactly 2 clk from accepted input to out_valid when unstalled.
//    Throughput: 1 op/clk.
//  - Stall (out_valid & ~out_ready): S1, S2 and all outputs hold; in_ready = 0.
//    No data is lost or duplicated.
//  - Bubbles are not collapsed: a bubble in S1 during a stall stays a bubble.
//  - Simultaneous out transfer and new input in the same cycle is legal.
//    The pipe shifts and the new input enters S1.
//  - Flags reflect out_result only and are meaningless when out_valid = 0.
//    They are still registered: reset values apply.
//  - Reset (async assert, sync-safe deassert by the system) sets:
//    - S1/S2 valid = 0; out_valid = 0; out_result = 0; out_tag = 0.
//    - out_zero = 1; out_ones = 0; out_parity = 0; out_pop = 0.
//    - Reset mid-operation discards all in-flight ops.
//  - No X-propagation: an undefined in_op with in_valid = 0 must not affect state.
// TESTING
//  1 Reset: hold rst_n=0 with random inputs -> out_valid=0, out_zero=1,
//    out_result=0, in_ready=1.
//  2 XNOR: a=8'hA5, b=8'h0F, op=011, tag=3 -> 2 clk later:
//    result=8'h55, pop=4, parity=0, zero=0, ones=0, tag=3.
//  3 All ops: a=8'hC3, b=8'h5A back-to-back, one per clk, out_ready=1 ->
//    results 42,DB,99,66,BD,24,3C,C3 on consecutive cycles.
//  4 Flags: NOR a=FF,b=00 -> result=00, zero=1;
//    XNOR a=b=8'h3C -> result=FF, ones=1, pop=8.
//  5 Backpressure: stream 4 tagged ops, drop out_ready for 3 clk mid-stream ->
//    outputs hold, in_ready=0, all 4 delivered once, in order.
//  6 Reset mid-flight: 2 ops in pipe, pulse rst_n low between edges ->
//    out_valid=0 at once, neither op is ever delivered.
//    Repeat tests 2-4 with WIDTH=16 and TAG_W=1.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - two-stage pipelined bitwise logic unit with tag pass-through and result flags
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 in_op,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_zero,
    output logic                       out_ones,
    output logic                       out_parity,
    output logic [$clog2(WIDTH+1)-1:0] out_pop
);
    localparam int POP_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_XNOR = 3'b011,
        OP_NAND = 3'b100,
        OP_NOR  = 3'b101,
        OP_NOTA = 3'b110,
        OP_PASS = 3'b111
    } op_e;

    logic             adv;
    logic [WIDTH-1:0] op_result;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_result;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_zero;
    logic             s1_ones;
    logic             s1_parity;
    logic [POP_W-1:0] s1_pop;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_result;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_zero;
    logic             s2_ones;
    logic             s2_parity;
    logic [POP_W-1:0] s2_pop;

    // The whole pipe moves in lockstep; only a held output blocks it.
    assign adv      = ~s2_valid | out_ready;
    assign in_ready = adv;

    always_comb begin
        op_result = '0;
        case (op_e'(in_op))
            OP_AND:  op_result = in_a & in_b;
            OP_OR:   op_result = in_a | in_b;
            OP_XOR:  op_result = in_a ^ in_b;
            OP_XNOR: op_result = ~(in_a ^ in_b);
            OP_NAND: op_result = ~(in_a & in_b);
            OP_NOR:  op_result = ~(in_a | in_b);
            OP_NOTA: op_result = ~in_a;
            OP_PASS: op_result = in_a;
            default: op_result = '0;
        endcase
    end

    // Data is only loaded for real ops so a garbage op code on an idle bus never reaches state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_result <= '0;
            s1_tag    <= '0;
        end else if (adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_result <= op_result;
                s1_tag    <= in_tag;
            end
        end
    end

    always_comb begin
        s1_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            s1_pop = s1_pop + POP_W'(s1_result[i]);
        end
        s1_zero   = ~|s1_result;
        s1_ones   = &s1_result;
        s1_parity = ^s1_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_tag    <= '0;
            s2_zero   <= 1'b1;
            s2_ones   <= 1'b0;
            s2_parity <= 1'b0;
            s2_pop    <= '0;
        end else if (adv) begin
            s2_valid  <= s1_valid;
            s2_result <= s1_result;
            s2_tag    <= s1_tag;
            s2_zero   <= s1_zero;
            s2_ones   <= s1_ones;
            s2_parity <= s1_parity;
            s2_pop    <= s1_pop;
        end
    end

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_tag    = s2_tag;
    assign out_zero   = s2_zero;
    assign out_ones   = s2_ones;
    assign out_parity = s2_parity;
    assign out_pop    = s2_pop;

endmodule
